// File: rtl/m65_bus_target_if.sv
// CPU-side bus and host-side FIFO handshakes of the 65-series bus target.
// The CPU core and host bench drive through master; the target uses slave.
interface m65_bus_target_if;
  logic        ph2;
  logic [15:0] A;
  logic        RWn;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        RDY;
  logic        IRQn;
  logic [7:0]  host_wdata;
  logic        host_wvalid;
  logic        host_wready;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        host_rready;

  modport master (
    output ph2, A, RWn, D_in, host_wdata, host_wvalid, host_rready,
    input  D_out, D_oe, RDY, IRQn, host_wready, host_rdata, host_rvalid
  );

  modport slave (
    input  ph2, A, RWn, D_in, host_wdata, host_wvalid, host_rready,
    output D_out, D_oe, RDY, IRQn, host_wready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/m65_bus_target.sv
// 16-byte register window on a 6502-style bus, paced by PH2, with read wait
// states and two byte FIFOs bridging host <-> CPU.
//   state   | meaning
//   S_IDLE  | waiting for a PH2 rise; decodes the captured access
//   S_STALL | read hit held off with RDY low until PH2 falls
//   S_DRIVE | read hit completing, D_out driven until PH2 falls
//   S_WRITE | write hit, D_in latched while PH2 high, committed on fall
module m65_bus_target #(
  parameter logic [11:0] BASE        = 12'hFF0,
  parameter int          WAIT_STATES = 0,
  parameter int          FIFO_DEPTH  = 4
) (
  input logic            clk,
  input logic            RESETn,
  m65_bus_target_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    WS       = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_DRIVE, S_WRITE} state_t;
  state_t state_q, state_d;

  logic        ph2_q, rise, fall, hit;
  logic [3:0]  off_q, off_d, cnt_q, cnt_d, cnt_eff;
  logic [15:0] stall_addr_q, stall_addr_d;
  logic        rdy_q, rdy_d, oe_q, oe_d, irqn_q;
  logic [7:0]  dout_q, dout_d, wdata_q, rd_data, status;
  logic [7:0]  scratch_q [8];
  logic        irqen_q, ovf_q, cpu_pop, cpu_wr, cpu_push;

  logic [7:0]    in_mem_q  [FIFO_DEPTH];
  logic [7:0]    out_mem_q [FIFO_DEPTH];
  logic [PW-1:0] in_wp_q, in_rp_q, out_wp_q, out_rp_q;
  logic [CW-1:0] in_cnt_q, out_cnt_q;
  logic          in_empty, in_full, out_empty, out_full;
  logic          in_push, out_pop;

  assign rise    = bus.ph2 & ~ph2_q;
  assign fall    = ~bus.ph2 & ph2_q;
  assign hit     = (bus.A[15:4] == BASE);
  // A wait count only carries over while the CPU keeps retrying the same address
  assign cnt_eff = (bus.A == stall_addr_q) ? cnt_q : 4'd0;

  assign in_empty  = (in_cnt_q == '0);
  assign in_full   = (in_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign in_push   = bus.host_wvalid & ~in_full;
  assign out_pop   = ~out_empty & bus.host_rready;
  assign cpu_push  = cpu_wr & (off_q == 4'h8) & ~out_full;

  assign status = {4'b0000, irqen_q & ~in_empty, ovf_q, out_full, ~in_empty};

  always_comb begin
    rd_data = 8'h00;
    if (!off_q[3]) begin
      rd_data = scratch_q[off_q[2:0]];
    end else begin
      case (off_q[2:0])
        3'd0:    rd_data = in_empty ? 8'h00 : in_mem_q[in_rp_q];
        3'd1:    rd_data = status;
        3'd2:    rd_data = {7'b0, irqen_q};
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    stall_addr_d = stall_addr_q;
    rdy_d        = rdy_q;
    cpu_pop      = 1'b0;
    cpu_wr       = 1'b0;
    unique case (state_q)
      S_IDLE: if (rise) begin
        off_d = bus.A[3:0];
        rdy_d = 1'b1;
        if (!hit) begin
          cnt_d = 4'd0;
        end else if (!bus.RWn) begin
          state_d = S_WRITE;
        end else if (cnt_eff == WS) begin
          state_d = S_DRIVE;
          cnt_d   = 4'd0;
        end else begin
          state_d      = S_STALL;
          cnt_d        = cnt_eff + 4'd1;
          rdy_d        = 1'b0;
          stall_addr_d = bus.A;
        end
      end
      S_STALL: if (fall) state_d = S_IDLE;
      S_DRIVE: if (fall) begin
        state_d = S_IDLE;
        cpu_pop = (off_q == 4'h8) & ~in_empty;
      end
      S_WRITE: if (fall) begin
        state_d = S_IDLE;
        cpu_wr  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign oe_d   = (state_q == S_DRIVE) & ~fall;
  assign dout_d = oe_d ? rd_data : dout_q;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_IDLE;
      ph2_q        <= 1'b0;
      off_q        <= 4'd0;
      cnt_q        <= 4'd0;
      stall_addr_q <= 16'h0000;
      rdy_q        <= 1'b1;
      oe_q         <= 1'b0;
      dout_q       <= 8'h00;
      wdata_q      <= 8'h00;
      irqn_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ph2_q        <= bus.ph2;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      stall_addr_q <= stall_addr_d;
      rdy_q        <= rdy_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      if (ph2_q) wdata_q <= bus.D_in;
      irqn_q       <= ~(irqen_q & ~in_empty);
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < 8; i++) scratch_q[i] <= 8'h00;
      irqen_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (cpu_wr) begin
      if (!off_q[3]) scratch_q[off_q[2:0]] <= wdata_q;
      if (off_q == 4'h8 && out_full) ovf_q <= 1'b1;
      if (off_q == 4'h9 && wdata_q[2]) ovf_q <= 1'b0;
      if (off_q == 4'hA) irqen_q <= wdata_q[0];
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        in_mem_q[i]  <= 8'h00;
        out_mem_q[i] <= 8'h00;
      end
    end else begin
      if (in_push) begin
        in_mem_q[in_wp_q] <= bus.host_wdata;
        in_wp_q           <= in_wp_q + PW'(1);
      end
      if (cpu_pop) in_rp_q <= in_rp_q + PW'(1);
      case ({in_push, cpu_pop})
        2'b10:   in_cnt_q <= in_cnt_q + CW'(1);
        2'b01:   in_cnt_q <= in_cnt_q - CW'(1);
        default: in_cnt_q <= in_cnt_q;
      endcase
      if (cpu_push) begin
        out_mem_q[out_wp_q] <= wdata_q;
        out_wp_q            <= out_wp_q + PW'(1);
      end
      if (out_pop) out_rp_q <= out_rp_q + PW'(1);
      case ({cpu_push, out_pop})
        2'b10:   out_cnt_q <= out_cnt_q + CW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  assign bus.D_out       = dout_q;
  assign bus.D_oe        = oe_q;
  assign bus.RDY         = rdy_q;
  assign bus.IRQn        = irqn_q;
  assign bus.host_wready = ~in_full;
  assign bus.host_rvalid = ~out_empty;
  assign bus.host_rdata  = out_mem_q[out_rp_q];
endmodule
